// File: rtl/dac_pkg.sv
// Shared constants and state encoding for the DAC scan sequencer.
// Imported by the sequencer, its port interface and the testbench.
package dac_pkg;

  localparam int DAC_NCH   = 32;
  localparam int DAC_VAL_W = 12;
  localparam logic [DAC_VAL_W-1:0] DAC_MAX = 12'hFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WRITE   = 3'd1;
  localparam logic [2:0] ST_UPD     = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;
  localparam logic [2:0] ST_DWELL   = 3'd5;
  localparam logic [2:0] ST_REPORT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_WRITE   = ST_WRITE,
    S_UPD     = ST_UPD,
    S_WAIT_HI = ST_WAIT_HI,
    S_WAIT_LO = ST_WAIT_LO,
    S_DWELL   = ST_DWELL,
    S_REPORT  = ST_REPORT
  } state_e;

endpackage

// File: rtl/dac_scan_seq_if.sv
// DAC-controller write/update pins and the point readout handshake of the scan sequencer.
// The sequencer uses the master modport; the DAC controller / readout side uses slave.
interface dac_scan_seq_if #(
  parameter int NPT_W = 16
);
  import dac_pkg::*;

  logic                 dac_we_o;
  logic [4:0]           dac_waddr_o;
  logic [15:0]          dac_dat_o;
  logic                 update_o;
  logic                 busy_i;
  logic                 point_valid_o;
  logic [DAC_VAL_W-1:0] point_val_o;
  logic [NPT_W-1:0]     point_idx_o;
  logic                 point_ack_i;

  modport master (
    output dac_we_o, dac_waddr_o, dac_dat_o, update_o,
    output point_valid_o, point_val_o, point_idx_o,
    input  busy_i, point_ack_i
  );

  modport slave (
    input  dac_we_o, dac_waddr_o, dac_dat_o, update_o,
    input  point_valid_o, point_val_o, point_idx_o,
    output busy_i, point_ack_i
  );

endinterface

// File: rtl/dac_scan_seq.sv
// Steps a 12-bit threshold over N points: writes every masked DAC channel, pulses update,
// waits out the controller's busy, dwells, then hands the point to the readout.
module dac_scan_seq
  import dac_pkg::*;
#(
  parameter int BUSY_TO = 16,
  parameter int DWELL_W = 16,
  parameter int NPT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [DAC_NCH-1:0]   chan_mask_i,
  input  logic [DAC_VAL_W-1:0] start_val_i,
  input  logic [DAC_VAL_W-1:0] step_val_i,
  input  logic [NPT_W-1:0]     n_points_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  dac_scan_seq_if.master       dac,
  output logic                 busy_o,
  output logic                 err_o
);

  // One counter serves the update pulse width, the busy timeout and the dwell.
  localparam int TO_W  = $clog2(BUSY_TO + 1);
  localparam int CNT_W = (DWELL_W > TO_W) ? DWELL_W : TO_W;

  state_e               state_q, state_d;
  logic [4:0]           chan_q, chan_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DAC_VAL_W-1:0] value_q, value_d;
  logic [NPT_W-1:0]     idx_q, idx_d;
  logic [NPT_W-1:0]     n_last_q, n_last_d;
  logic [DAC_NCH-1:0]   mask_q, mask_d;
  logic [DAC_VAL_W-1:0] step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic [DAC_VAL_W:0]   sum;
  logic                 writing;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    idx_d    = idx_q;
    n_last_d = n_last_q;
    mask_d   = mask_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    abort_d  = abort_q;
    err_d    = err_q;
    sum      = {1'b0, value_q} + {1'b0, step_q};

    if (abort_i && state_q != S_IDLE) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_WRITE;
          mask_d   = chan_mask_i;
          step_d   = step_val_i;
          dwell_d  = dwell_i;
          n_last_d = (n_points_i == '0) ? '0 : n_points_i - NPT_W'(1);
          value_d  = start_val_i;
          idx_d    = '0;
          chan_d   = '0;
          abort_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_WRITE: begin
        chan_d = chan_q + 5'd1;
        if (chan_q == 5'd31) begin
          state_d = S_UPD;
          cnt_d   = '0;
        end
      end
      S_UPD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q[0]) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        if (dac.busy_i) begin
          state_d = S_WAIT_LO;
        end else if (cnt_q == CNT_W'(BUSY_TO)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!dac.busy_i) begin
          state_d = S_DWELL;
          cnt_d   = CNT_W'(dwell_q);
        end
      end
      S_DWELL: begin
        if (cnt_q == '0) state_d = S_REPORT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_REPORT: begin
        if (dac.point_ack_i) begin
          if (idx_q == n_last_q || abort_q || abort_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WRITE;
            chan_d  = '0;
            idx_d   = idx_q + NPT_W'(1);
            // The 13-bit sum's carry means the step ran past full scale.
            value_d = sum[DAC_VAL_W] ? DAC_MAX : sum[DAC_VAL_W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: reset is sampled on the clock edge only; all state here uses non-blocking updates.
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      chan_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      idx_q    <= '0;
      n_last_q <= '0;
      mask_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      idx_q    <= idx_d;
      n_last_q <= n_last_d;
      mask_q   <= mask_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  assign writing           = (state_q == S_WRITE) && mask_q[chan_q];
  assign dac.dac_we_o      = writing;
  assign dac.dac_waddr_o   = writing ? chan_q : '0;
  assign dac.dac_dat_o     = writing ? {4'b0, value_q} : '0;
  assign dac.update_o      = (state_q == S_UPD);
  assign dac.point_valid_o = (state_q == S_REPORT);
  assign dac.point_val_o   = (state_q == S_REPORT) ? value_q : '0;
  assign dac.point_idx_o   = (state_q == S_REPORT) ? idx_q : '0;
  assign busy_o            = (state_q != S_IDLE);
  assign err_o             = err_q;

endmodule

// File: tb/tb_dac_scan_seq.sv
// Directed bench for dac_scan_seq: expected DAC writes and readout points are queued when a
// scan is started and compared as the DAC controller model and readout responder observe them.
module tb_dac_scan_seq;
  import dac_pkg::*;

  localparam int BUSY_TO = 16;
  localparam int DWELL_W = 16;
  localparam int NPT_W   = 16;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] dat;
  } wr_t;

  typedef struct {
    logic [11:0] val;
    logic [15:0] idx;
  } pt_t;

  logic               clk_i = 1'b0;
  logic               rst_n_i, start_i, abort_i;
  logic [31:0]        chan_mask_i;
  logic [11:0]        start_val_i, step_val_i;
  logic [NPT_W-1:0]   n_points_i;
  logic [DWELL_W-1:0] dwell_i;
  logic               busy_o, err_o;

  dac_scan_seq_if #(.NPT_W(NPT_W)) dac ();

  dac_scan_seq #(.BUSY_TO(BUSY_TO), .DWELL_W(DWELL_W), .NPT_W(NPT_W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .chan_mask_i (chan_mask_i),
    .start_val_i (start_val_i),
    .step_val_i  (step_val_i),
    .n_points_i  (n_points_i),
    .dwell_i     (dwell_i),
    .dac         (dac),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int  n_run = 0, n_fail = 0;
  int  we_cnt = 0, upd_pulses = 0;
  int  ack_mode = 1;   // 0: never ack, 1: ack one cycle after valid, 2: ack held high
  int  busy_mode = 1;  // 0: controller never raises busy
  int  busy_len = 3;
  int  busy_cnt = 0;
  bit  upd_prev = 1'b0;
  wr_t wr_q[$];
  pt_t pt_q[$];
  wr_t mon_w;
  pt_t mon_p;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DAC write monitor and update pulse counter.
  always @(negedge clk_i) begin
    if (dac.update_o && !upd_prev) upd_pulses++;
    upd_prev = dac.update_o;
    if (dac.dac_we_o) begin
      we_cnt++;
      if (wr_q.size() == 0) begin
        n_run++;
        n_fail++;
        $error("FAIL unexpected_write: observed addr %0d dat 0x%0h, expected no write",
               dac.dac_waddr_o, dac.dac_dat_o);
      end else begin
        mon_w = wr_q.pop_front();
        check("waddr", 32'(dac.dac_waddr_o), 32'(mon_w.addr));
        check("wdat", 32'(dac.dac_dat_o), 32'(mon_w.dat));
      end
    end
  end

  // DAC controller model: busy rises during update and stays high busy_len cycles after it.
  initial begin
    dac.busy_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (busy_mode != 0 && dac.update_o) busy_cnt = busy_len;
      else if (busy_cnt > 0)              busy_cnt--;
      dac.busy_i = (busy_mode != 0) && (busy_cnt > 0);
    end
  end

  // Readout responder: decides ack for the next edge and scores the point being handed over.
  initial begin
    dac.point_ack_i = 1'b0;
    forever begin
      @(negedge clk_i);
      case (ack_mode)
        0:       dac.point_ack_i = 1'b0;
        2:       dac.point_ack_i = 1'b1;
        default: dac.point_ack_i = dac.point_valid_o && !dac.point_ack_i;
      endcase
      if (dac.point_valid_o && dac.point_ack_i) begin
        if (pt_q.size() == 0) begin
          n_run++;
          n_fail++;
          $error("FAIL unexpected_point: observed idx %0d, expected none", dac.point_idx_o);
        end else begin
          mon_p = pt_q.pop_front();
          check("point_val", 32'(dac.point_val_o), 32'(mon_p.val));
          check("point_idx", 32'(dac.point_idx_o), 32'(mon_p.idx));
        end
      end
    end
  end

  // Queues the expected writes/points for n_exp points, then pulses start_i.
  task automatic start_scan(input logic [31:0] mask, input logic [11:0] sv, input logic [11:0] st,
                            input logic [15:0] n, input logic [15:0] dw, input int n_exp);
    int  v;
    wr_t w;
    pt_t p;
    v = int'(sv);
    for (int i = 0; i < n_exp; i++) begin
      for (int c = 0; c < 32; c++) begin
        if (mask[c]) begin
          w.addr = 5'(c);
          w.dat  = {4'b0, 12'(v)};
          wr_q.push_back(w);
        end
      end
      p.val = 12'(v);
      p.idx = 16'(i);
      pt_q.push_back(p);
      v = v + int'(st);
      if (v > 4095) v = 4095;
    end
    chan_mask_i = mask;
    start_val_i = sv;
    step_val_i  = st;
    n_points_i  = n;
    dwell_i     = dw;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
    chan_mask_i = ~mask;  // config is latched; scrambling it must not matter
    start_val_i = 12'hA5A;
    step_val_i  = 12'h7FF;
    n_points_i  = 16'd7;
    dwell_i     = 16'd50;
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("err_after_start", 32'(err_o), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_update(input logic level, input string tag);
    int k;
    k = 0;
    while (dac.update_o !== level && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check(tag, 32'(dac.update_o), 32'(level));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, u0, cyc;
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    chan_mask_i = '0; start_val_i = '0; step_val_i = '0; n_points_i = '0; dwell_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_we", 32'(dac.dac_we_o), 32'd0);
    check("rst_update", 32'(dac.update_o), 32'd0);
    check("rst_valid", 32'(dac.point_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Full mask, three points, ack one cycle after valid.
    w0 = we_cnt; u0 = upd_pulses;
    start_scan(32'hFFFF_FFFF, 12'h100, 12'h010, 16'd3, 16'd4, 3);
    wait_idle(2000, "t1_idle");
    check("t1_writes", 32'(we_cnt - w0), 32'd96);
    check("t1_updates", 32'(upd_pulses - u0), 32'd3);
    check("t1_points_left", 32'(pt_q.size()), 32'd0);

    // Sparse mask: still 32 WRITE cycles, update held exactly 2 cycles.
    w0 = we_cnt;
    start_scan(32'h0000_0005, 12'h3C0, 12'h001, 16'd1, 16'd2, 1);
    cyc = 0;
    while (!dac.update_o && cyc < 100) begin
      cyc++;
      @(negedge clk_i);
    end
    check("t2_write_cycles", 32'(cyc), 32'd32);
    cyc = 0;
    while (dac.update_o && cyc < 10) begin
      cyc++;
      @(negedge clk_i);
    end
    check("t2_update_width", 32'(cyc), 32'd2);
    wait_idle(500, "t2_idle");
    check("t2_writes", 32'(we_cnt - w0), 32'd2);

    // Saturation; first point held without ack to check valid and data are stable.
    ack_mode = 0;
    start_scan(32'h8000_0000, 12'hFF0, 12'h020, 16'd3, 16'd1, 3);
    cyc = 0;
    while (!dac.point_valid_o && cyc < 200) begin
      cyc++;
      @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    check("t3_valid_held", 32'(dac.point_valid_o), 32'd1);
    check("t3_val_held", 32'(dac.point_val_o), 32'h0FF0);
    check("t3_idx_held", 32'(dac.point_idx_o), 32'd0);
    ack_mode = 1;
    wait_idle(1000, "t3_idle");
    check("t3_points_left", 32'(pt_q.size()), 32'd0);

    // n_points=0 runs one point; dwell=0; ack already high when valid rises.
    ack_mode = 2;
    start_scan(32'h0000_0001, 12'h007, 12'h100, 16'd0, 16'd0, 1);
    wait_idle(500, "t4_idle");
    check("t4_points_left", 32'(pt_q.size()), 32'd0);
    ack_mode = 1;
    @(negedge clk_i);

    // busy_i never rises: timeout sets err_o and returns to IDLE.
    busy_mode = 0;
    start_scan(32'h0000_0000, 12'h200, 12'h010, 16'd2, 16'd1, 0);
    wait_update(1'b1, "t5_update_seen");
    wait_update(1'b0, "t5_update_end");
    cyc = 0;
    while (!err_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check("t5_timeout_cycles", 32'(cyc), 32'(BUSY_TO + 1));
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_busy_o", 32'(busy_o), 32'd0);
    check("t5_valid", 32'(dac.point_valid_o), 32'd0);
    busy_mode = 1;
    @(negedge clk_i);
    start_scan(32'h0000_0002, 12'h321, 12'h001, 16'd1, 16'd1, 1);
    wait_idle(500, "t5_restart_idle");

    // Abort during WRITE of point 1: point 1 still reported, nothing after it.
    w0 = we_cnt;
    start_scan(32'h0000_0001, 12'h050, 12'h005, 16'd10, 16'd2, 2);
    cyc = 0;
    while (pt_q.size() != 1 && cyc < 500) begin
      @(negedge clk_i);
      cyc++;
    end
    repeat (3) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    wait_idle(500, "t6_idle");
    check("t6_points_left", 32'(pt_q.size()), 32'd0);
    check("t6_writes", 32'(we_cnt - w0), 32'd2);

    // Reset while in WAIT_LO, then a clean scan (with an ignored abort in IDLE first).
    busy_len = 8;
    start_scan(32'h0000_0001, 12'h444, 12'h001, 16'd2, 16'd3, 2);
    wait_update(1'b1, "t7_update_seen");
    wait_update(1'b0, "t7_update_end");
    @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("t7_rst_busy", 32'(busy_o), 32'd0);
    check("t7_rst_update", 32'(dac.update_o), 32'd0);
    check("t7_rst_we", 32'(dac.dac_we_o), 32'd0);
    check("t7_rst_valid", 32'(dac.point_valid_o), 32'd0);
    check("t7_rst_err", 32'(err_o), 32'd0);
    rst_n_i = 1'b1;
    wr_q.delete();
    pt_q.delete();
    busy_len = 3;
    repeat (10) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    @(negedge clk_i);
    start_scan(32'h8000_0001, 12'h800, 12'h400, 16'd2, 16'd1, 2);
    wait_idle(1000, "t7_idle");
    check("t7_points_left", 32'(pt_q.size()), 32'd0);
    check("writes_left", 32'(wr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
